// File: rtl/sine_pkg.sv
// Shared definitions for the quarter-wave sine path: quadrant codes, table geometry,
// sequencer states and the quadrant address-mirroring helper.
package sine_pkg;

  localparam logic [1:0] PEAK   = 2'b00;
  localparam logic [1:0] FALL   = 2'b01;
  localparam logic [1:0] TROUGH = 2'b10;
  localparam logic [1:0] RISE   = 2'b11;

  localparam int QTR_LEN  = 128;
  localparam int IDX_W    = 7;
  localparam int SAMPLE_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    HOLD
  } state_t;

  // FALL and RISE walk the quarter wave backwards; ~idx equals (QTR_LEN-1)-idx for 7 bits.
  function automatic logic [IDX_W-1:0] mirror_idx(input logic [1:0] q,
                                                  input logic [IDX_W-1:0] idx);
    return q[0] ? ~idx : idx;
  endfunction

endpackage

// File: rtl/sine_strobe_div.sv
// Sample-rate divider: counts 0..SAMPLE_DIV-1 while enabled and strobes on the last count.
// Held at zero while disabled so a restart always waits a full period.
module sine_strobe_div #(
  parameter int unsigned SAMPLE_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic strobe
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign strobe = enable && (cnt == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || strobe) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sine_reader.sv
// Phase-accumulator sequencer for the quarter-wave sine memory with valid/ready sample output.
// Optional SINE_READER_OVERRUN_CNT_EN adds a saturating count of strobes dropped while busy.
module sine_reader
  import sine_pkg::*;
#(
  parameter int PHASE_W    = 16,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PHASE_W-1:0]  phase_step,
  input  logic                phase_clr,
  output logic [7:0]          read_address,
  output logic [1:0]          read_state,
  input  logic [SAMPLE_W-1:0] read_data,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  input  logic                sample_ready
`ifdef SINE_READER_OVERRUN_CNT_EN
  ,
  output logic [15:0]         overrun_count
`endif
);

  logic               strobe;
  logic [PHASE_W-1:0] phase;
  state_t             state;
  logic [1:0]         quad;
  logic [IDX_W-1:0]   idx;
  logic               take;
  logic               capture;

  assign quad = phase[PHASE_W-1 -: 2];
  assign idx  = phase[PHASE_W-3 -: IDX_W];
  assign take = sample_valid && sample_ready;
  // Memory data is valid in CAPTURE and stays valid in HOLD because the address is parked.
  assign capture = ((state == CAPTURE) || (state == HOLD)) && (!sample_valid || sample_ready);

  sine_strobe_div #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .strobe (strobe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      phase        <= '0;
      read_address <= '0;
      read_state   <= PEAK;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      // A clear coinciding with ISSUE discards that sample's step.
      if (phase_clr) begin
        phase <= '0;
      end else if (state == ISSUE) begin
        phase <= phase + phase_step;
      end

      if (capture) begin
        sample       <= read_data;
        sample_valid <= 1'b1;
      end else if (take) begin
        sample_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (strobe) state <= ISSUE;
        end
        ISSUE: begin
          read_address <= {1'b0, mirror_idx(quad, idx)};
          read_state   <= quad;
          state        <= WAIT;
        end
        WAIT: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          state <= capture ? IDLE : HOLD;
        end
        HOLD: begin
          if (capture) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SINE_READER_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_count <= '0;
    end else if (phase_clr) begin
      overrun_count <= '0;
    end else if (strobe && (state != IDLE) && (overrun_count != 16'hFFFF)) begin
      overrun_count <= overrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sine_reader.sv
// Self-checking bench for sine_reader: timestamp-based transaction model plus directed literals.
// The sample memory is modelled as a registered read returning {read_state, read_address}.
module tb_sine_reader;

  localparam int PHASE_W = 16;
  localparam int DIV     = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [15:0]  phase_step = '0;
  logic         phase_clr = 1'b0;
  logic [7:0]   read_address;
  logic [1:0]   read_state;
  logic [9:0]   read_data;
  logic [9:0]   sample;
  logic         sample_valid;
  logic         sample_ready = 1'b1;
`ifdef SINE_READER_OVERRUN_CNT_EN
  logic [15:0]  overrun_count;
`endif

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  sine_reader #(
    .PHASE_W    (PHASE_W),
    .SAMPLE_DIV (DIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .phase_step   (phase_step),
    .phase_clr    (phase_clr),
    .read_address (read_address),
    .read_state   (read_state),
    .read_data    (read_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready)
`ifdef SINE_READER_OVERRUN_CNT_EN
    ,
    .overrun_count(overrun_count)
`endif
  );

  // Registered sample memory: word = {state, address}.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) read_data <= '0;
    else        read_data <= {read_state, read_address};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected memory word for a phase value, straight from the quadrant/index rules.
  function automatic logic [9:0] word_of(input logic [15:0] ph);
    int q, i, a;
    q = int'(ph) / 16384;
    i = (int'(ph) / 128) % 128;
    a = (q % 2 == 1) ? 127 - i : i;
    return 10'(q * 256 + a);
  endfunction

  // k-th sample of a 0x0080-step sweep from phase 0.
  function automatic logic [9:0] sweep_word(input int k);
    int kk, q, r;
    kk = k % 512;
    q  = kk / 128;
    r  = kk % 128;
    return 10'(q * 256 + ((q % 2 == 1) ? 127 - r : r));
  endfunction

  // ---------------- behavioural model (edge-counted transactions) ----------------
  int          m_cyc, m_div, m_t_issue, m_t_due, m_ovr;
  logic [15:0] m_phase;
  logic [9:0]  m_word, m_sample;
  bit          m_busy, m_valid;

  wire m_strobe    = enable && (m_div == DIV - 1);
  wire m_issue_now = m_busy && (m_cyc == m_t_issue);
  wire m_cap       = m_busy && (m_cyc >= m_t_due) && (!m_valid || sample_ready);
  wire m_take      = m_valid && sample_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0; m_div <= 0; m_t_issue <= 0; m_t_due <= 0; m_ovr <= 0;
      m_phase <= '0; m_word <= '0; m_sample <= '0; m_busy <= 1'b0; m_valid <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      m_div <= (enable && !m_strobe) ? m_div + 1 : 0;
      if (m_issue_now) m_word <= word_of(m_phase);
      if (phase_clr)        m_phase <= '0;
      else if (m_issue_now) m_phase <= m_phase + phase_step;
      if (m_cap) begin
        m_busy <= 1'b0; m_sample <= m_word; m_valid <= 1'b1;
      end else if (m_take) begin
        m_valid <= 1'b0;
      end
      if (m_strobe && !m_busy) begin
        m_busy <= 1'b1; m_t_issue <= m_cyc + 1; m_t_due <= m_cyc + 3;
      end
      if (phase_clr)                                 m_ovr <= 0;
      else if (m_strobe && m_busy && m_ovr < 65535) m_ovr <= m_ovr + 1;
    end
  end

  always @(negedge clk) begin
    check("model_addr",  32'(read_address), 32'(m_word[7:0]));
    check("model_state", 32'(read_state),   32'(m_word[9:8]));
    check("model_sample", 32'(sample),      32'(m_sample));
    check("model_valid", 32'(sample_valid), 32'(m_valid));
`ifdef SINE_READER_OVERRUN_CNT_EN
    check("model_overrun", 32'(overrun_count), 32'(m_ovr));
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    phase_clr = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int n);
    bit ok;
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        ok = 1'b1;
        n  = i + 1;
        break;
      end
    end
    if (!ok) check("wait_valid_timeout", 32'(max), 32'(0));
  endtask

  task automatic expect_next(input string name, input logic [9:0] w);
    int n;
    wait_valid(3 * DIV, n);
    check(name, 32'(sample), 32'(w));
    @(negedge clk);
  endtask

  initial begin
    int n;
    bit moved;
    logic [9:0] seq [5];
    seq = '{10'h000, 10'h17F, 10'h200, 10'h37F, 10'h000};

    // Reset state.
    run(3);
    check("rst_addr",   32'(read_address), 32'(0));
    check("rst_state",  32'(read_state),   32'(0));
    check("rst_sample", 32'(sample),       32'(0));
    check("rst_valid",  32'(sample_valid), 32'(0));
    rst_n = 1'b1;
    run(2);

    // Full-cycle sweep with step 0x0080, including wrap back to 0/00.
    phase_step = 16'h0080;
    enable     = 1'b1;
    for (int k = 0; k <= 512; k++) begin
      wait_valid(3 * DIV, n);
      if (k == 0) check("first_latency", 32'(n), 32'(DIV + 3));
      check("sweep_sample", 32'(sample), 32'(sweep_word(k)));
      @(negedge clk);
    end
    enable = 1'b0;
    run(DIV);

    // Quarter-turn steps, then a clear mid-run.
    pulse_clr();
    phase_step = 16'h4000;
    enable     = 1'b1;
    for (int k = 0; k < 5; k++) expect_next("quarter_seq", seq[k]);
    pulse_clr();
    expect_next("after_clr", 10'h000);
    enable = 1'b0;
    run(DIV);

    // Back-pressure: first sample held, later strobes dropped.
    pulse_clr();
    sample_ready = 1'b0;
    enable       = 1'b1;
    run(4 * DIV + DIV / 2);
    check("hold_valid",  32'(sample_valid), 32'(1));
    check("hold_sample", 32'(sample),       32'(0));
    check("hold_addr",   32'(read_address), 32'(127));
    check("hold_state",  32'(read_state),   32'(1));
`ifdef SINE_READER_OVERRUN_CNT_EN
    check("hold_overrun", 32'(overrun_count), 32'(2));
`endif
    sample_ready = 1'b1;
    @(negedge clk);
    check("release_sample", 32'(sample),       32'(10'h17F));
    check("release_valid",  32'(sample_valid), 32'(1));
    @(negedge clk);
    check("release_taken",  32'(sample_valid), 32'(0));
    expect_next("after_hold", 10'h200);
    enable = 1'b0;
    run(DIV);

    // enable dropped while a read is in WAIT.
    pulse_clr();
    phase_step = 16'h2000;
    enable     = 1'b1;
    wait_valid(3 * DIV, n);
    check("en_first", 32'(sample), 32'(0));
    run(DIV - 2);
    enable = 1'b0;
    wait_valid(4, n);
    check("en_wait_capture", 32'(sample), 32'(10'h040));
    moved = 1'b0;
    for (int i = 0; i < 3 * DIV; i++) begin
      @(negedge clk);
      if (sample_valid || read_address != 8'd64) moved = 1'b1;
    end
    check("halted_quiet", 32'(moved), 32'(0));
    enable = 1'b1;
    wait_valid(3 * DIV, n);
    check("resume_latency", 32'(n), 32'(DIV + 3));
    check("resume_sample", 32'(sample), 32'(10'h17F));
    @(negedge clk);

    // Asynchronous reset while parked in HOLD.
    phase_step   = 16'h4000;
    sample_ready = 1'b0;
    run(3 * DIV);
    check("prereset_valid", 32'(sample_valid), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_addr",   32'(read_address), 32'(0));
    check("async_state",  32'(read_state),   32'(0));
    check("async_sample", 32'(sample),       32'(0));
    check("async_valid",  32'(sample_valid), 32'(0));
`ifdef SINE_READER_OVERRUN_CNT_EN
    check("async_overrun", 32'(overrun_count), 32'(0));
`endif
    run(2);
    sample_ready = 1'b1;
    rst_n        = 1'b1;
    wait_valid(3 * DIV, n);
    check("postrst_latency", 32'(n), 32'(DIV + 3));
    check("postrst_addr",  32'(read_address), 32'(0));
    check("postrst_state", 32'(read_state),   32'(0));
    @(negedge clk);
    expect_next("postrst_second", 10'h17F);

    // Randomized traffic against the model.
    phase_step = 16'($urandom);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      phase_clr    = ($urandom_range(0, 79) == 0);
      sample_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) phase_step = 16'($urandom);
    end
    phase_clr = 1'b0;
    enable    = 1'b0;
    run(2 * DIV);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
